// File: rtl/regfile_scoreboard_if.sv
// Issue/writeback bundle between decode, the scoreboard and the register-file write port.
interface regfile_scoreboard_if #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int STALL_W  = 16
);
    logic                issue_valid;
    logic [ADDR_W-1:0]   issue_src1;
    logic                issue_src1_used;
    logic [ADDR_W-1:0]   issue_src2;
    logic                issue_src2_used;
    logic [ADDR_W-1:0]   issue_dst;
    logic                issue_dst_used;
    logic                issue_ready;
    logic                wb_valid;
    logic [ADDR_W-1:0]   wb_addr;
    logic                flush;
    logic [NUM_REGS-1:0] busy_mask;
    logic [ADDR_W:0]     pending_count;
    logic [STALL_W-1:0]  stall_cycles;
    logic                wb_error;

    modport master (
        output issue_valid, issue_src1, issue_src1_used, issue_src2, issue_src2_used,
               issue_dst, issue_dst_used, wb_valid, wb_addr, flush,
        input  issue_ready, busy_mask, pending_count, stall_cycles, wb_error
    );

    modport slave (
        input  issue_valid, issue_src1, issue_src1_used, issue_src2, issue_src2_used,
               issue_dst, issue_dst_used, wb_valid, wb_addr, flush,
        output issue_ready, busy_mask, pending_count, stall_cycles, wb_error
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for the 16x64 register file: gates issue on RAW/WAW hazards,
// clears on writeback, drops everything on flush.
module regfile_scoreboard #(
    parameter int NUM_REGS  = 16,
    parameter int ADDR_W    = 4,
    parameter int WB_BYPASS = 0,
    parameter int STALL_W   = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_scoreboard_if.slave sb
);
    logic [NUM_REGS-1:0] r_busy;
    logic [ADDR_W:0]     r_pending;
    logic [STALL_W-1:0]  r_stall;
    logic                r_wb_error;

    logic                w_wb_fire;
    logic [NUM_REGS-1:0] w_wb_onehot;
    logic [NUM_REGS-1:0] w_clr;
    logic                w_haz_src1;
    logic                w_haz_src2;
    logic                w_haz_dst;
    logic                w_ready;
    logic                w_issue_fire;
    logic                w_stall;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [ADDR_W:0]     w_pending_nxt;
    logic                w_wb_err_set;

    assign w_wb_fire   = sb.wb_valid && !sb.flush;
    assign w_wb_onehot = NUM_REGS'(1) << sb.wb_addr;
    // With bypass, a same-cycle writeback makes the operand readable, so it masks the hazard.
    assign w_clr       = (WB_BYPASS != 0 && w_wb_fire) ? w_wb_onehot : '0;

    assign w_haz_src1 = sb.issue_src1_used && r_busy[sb.issue_src1] && !w_clr[sb.issue_src1];
    assign w_haz_src2 = sb.issue_src2_used && r_busy[sb.issue_src2] && !w_clr[sb.issue_src2];
    assign w_haz_dst  = sb.issue_dst_used  && r_busy[sb.issue_dst]  && !w_clr[sb.issue_dst];

    assign w_ready      = !sb.flush && !(w_haz_src1 || w_haz_src2 || w_haz_dst);
    assign w_issue_fire = sb.issue_valid && w_ready;
    assign w_stall      = sb.issue_valid && !w_ready;
    assign w_wb_err_set = w_wb_fire && !r_busy[sb.wb_addr];

    always_comb begin
        w_busy_nxt = r_busy;
        if (sb.flush) begin
            w_busy_nxt = '0;
        end else begin
            if (w_wb_fire)
                w_busy_nxt = w_busy_nxt & ~w_wb_onehot;
            // Set applied after clear so an issue to the register being written back stays busy.
            if (w_issue_fire && sb.issue_dst_used)
                w_busy_nxt[sb.issue_dst] = 1'b1;
        end
    end

    always_comb begin
        w_pending_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++)
            w_pending_nxt = w_pending_nxt + (ADDR_W+1)'(w_busy_nxt[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_pending  <= '0;
            r_stall    <= '0;
            r_wb_error <= 1'b0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_pending <= w_pending_nxt;
            if (w_stall && r_stall != {STALL_W{1'b1}})
                r_stall <= r_stall + 1'b1;
            if (w_wb_err_set)
                r_wb_error <= 1'b1;
        end
    end

    assign sb.issue_ready   = w_ready;
    assign sb.busy_mask     = r_busy;
    assign sb.pending_count = r_pending;
    assign sb.stall_cycles  = r_stall;
    assign sb.wb_error      = r_wb_error;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Drives two scoreboards (no bypass / 16-bit stall counter, bypass / 4-bit counter) with
// the same directed stimulus and checks both against a per-register model every cycle.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       t_valid, t_s1u, t_s2u, t_du, t_wbv, t_flush;
    logic [3:0] t_s1, t_s2, t_dst, t_wba;

    regfile_scoreboard_if #(.NUM_REGS(16), .ADDR_W(4), .STALL_W(16)) if0 ();
    regfile_scoreboard_if #(.NUM_REGS(16), .ADDR_W(4), .STALL_W(4))  if1 ();

    assign if0.issue_valid = t_valid;  assign if1.issue_valid = t_valid;
    assign if0.issue_src1 = t_s1;      assign if1.issue_src1 = t_s1;
    assign if0.issue_src1_used = t_s1u; assign if1.issue_src1_used = t_s1u;
    assign if0.issue_src2 = t_s2;      assign if1.issue_src2 = t_s2;
    assign if0.issue_src2_used = t_s2u; assign if1.issue_src2_used = t_s2u;
    assign if0.issue_dst = t_dst;      assign if1.issue_dst = t_dst;
    assign if0.issue_dst_used = t_du;  assign if1.issue_dst_used = t_du;
    assign if0.wb_valid = t_wbv;       assign if1.wb_valid = t_wbv;
    assign if0.wb_addr = t_wba;        assign if1.wb_addr = t_wba;
    assign if0.flush = t_flush;        assign if1.flush = t_flush;

    regfile_scoreboard #(.NUM_REGS(16), .ADDR_W(4), .WB_BYPASS(0), .STALL_W(16))
        dut0 (.clk(clk), .rst_n(rst_n), .sb(if0));
    regfile_scoreboard #(.NUM_REGS(16), .ADDR_W(4), .WB_BYPASS(1), .STALL_W(4))
        dut1 (.clk(clk), .rst_n(rst_n), .sb(if1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: per-register busy flags, sticky error, saturating stall count.
    bit m_busy [2][16];
    bit m_err  [2];
    int m_stall[2];
    localparam int BYP [2]  = '{0, 1};
    localparam int SMAX [2] = '{65535, 15};

    function automatic bit op_blocked(int d, bit used, int r);
        bit wb_resolves;
        wb_resolves = (BYP[d] == 1) && t_wbv && (int'(t_wba) == r);
        return used && m_busy[d][r] && !wb_resolves;
    endfunction

    function automatic bit m_ready(int d);
        if (t_flush) return 1'b0;
        return !(op_blocked(d, t_s1u, int'(t_s1)) || op_blocked(d, t_s2u, int'(t_s2)) ||
                 op_blocked(d, t_du, int'(t_dst)));
    endfunction

    function automatic int m_mask(int d);
        int m = 0;
        for (int r = 0; r < 16; r++) if (m_busy[d][r]) m += (1 << r);
        return m;
    endfunction

    function automatic int m_count(int d);
        int c = 0;
        for (int r = 0; r < 16; r++) if (m_busy[d][r]) c++;
        return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int r = 0; r < 16; r++) m_busy[d][r] <= 1'b0;
                m_err[d]   <= 1'b0;
                m_stall[d] <= 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit nb [16];
                bit rdy;
                rdy = m_ready(d);
                nb = m_busy[d];
                if (t_flush) begin
                    for (int r = 0; r < 16; r++) nb[r] = 1'b0;
                end else begin
                    if (t_wbv) begin
                        if (m_busy[d][t_wba]) nb[t_wba] = 1'b0;
                        else m_err[d] <= 1'b1;
                    end
                    if (t_valid && rdy && t_du) nb[t_dst] = 1'b1;
                end
                m_busy[d] <= nb;
                if (t_valid && !rdy && m_stall[d] < SMAX[d]) m_stall[d] <= m_stall[d] + 1;
            end
        end
    end

    // Every negedge: both DUTs against the model.
    always @(negedge clk) begin
        chk("dut0.issue_ready",   int'(if0.issue_ready),   int'(m_ready(0)));
        chk("dut0.busy_mask",     int'(if0.busy_mask),     m_mask(0));
        chk("dut0.pending_count", int'(if0.pending_count), m_count(0));
        chk("dut0.stall_cycles",  int'(if0.stall_cycles),  m_stall[0]);
        chk("dut0.wb_error",      int'(if0.wb_error),      int'(m_err[0]));
        chk("dut1.issue_ready",   int'(if1.issue_ready),   int'(m_ready(1)));
        chk("dut1.busy_mask",     int'(if1.busy_mask),     m_mask(1));
        chk("dut1.pending_count", int'(if1.pending_count), m_count(1));
        chk("dut1.stall_cycles",  int'(if1.stall_cycles),  m_stall[1]);
        chk("dut1.wb_error",      int'(if1.wb_error),      int'(m_err[1]));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        t_valid = 0; t_s1u = 0; t_s2u = 0; t_du = 0; t_wbv = 0; t_flush = 0;
        t_s1 = 0; t_s2 = 0; t_dst = 0; t_wba = 0;
    endtask

    task automatic issue(input bit s1u, input int s1, input bit s2u, input int s2,
                         input bit du, input int dst);
        t_valid = 1; t_s1u = s1u; t_s1 = 4'(s1); t_s2u = s2u; t_s2 = 4'(s2);
        t_du = du; t_dst = 4'(dst);
    endtask

    initial begin
        idle();
        repeat (3) cyc();
        chk("lit reset busy0", int'(if0.busy_mask), 0);
        chk("lit reset ready0", int'(if0.issue_ready), 1);
        rst_n = 1;

        // dst=3 issue
        issue(0, 0, 0, 0, 1, 3);
        #1 chk("lit T1 ready0", int'(if0.issue_ready), 1);
        cyc();
        chk("lit T1 busy0", int'(if0.busy_mask), 'h0008);
        chk("lit T1 pend0", int'(if0.pending_count), 1);

        // RAW on r3 with same-cycle writeback
        issue(1, 3, 0, 0, 0, 0);
        t_wbv = 1; t_wba = 3;
        #1 chk("lit RAW ready0", int'(if0.issue_ready), 0);
        chk("lit RAW ready1", int'(if1.issue_ready), 1);
        cyc();
        chk("lit RAW stall0", int'(if0.stall_cycles), 1);
        chk("lit RAW busy0", int'(if0.busy_mask), 0);
        chk("lit RAW busy1", int'(if1.busy_mask), 0);
        t_wbv = 0;
        #1 chk("lit RAW retry ready0", int'(if0.issue_ready), 1);
        cyc();
        idle();

        // WAW on flag register, then collision
        issue(0, 0, 0, 0, 1, 15);
        cyc();
        #1 chk("lit WAW ready0", int'(if0.issue_ready), 0);
        chk("lit WAW ready1", int'(if1.issue_ready), 0);
        cyc();
        t_wbv = 1; t_wba = 15;
        #1 chk("lit coll ready1", int'(if1.issue_ready), 1);
        cyc();
        chk("lit coll busy1", int'(if1.busy_mask), 'h8000);
        chk("lit coll busy0", int'(if0.busy_mask), 0);
        idle();

        // writeback to idle register
        t_wbv = 1; t_wba = 7;
        cyc();
        chk("lit err0", int'(if0.wb_error), 1);
        t_wbv = 0;
        cyc();
        chk("lit err0 sticky", int'(if0.wb_error), 1);

        // drain r15 on dut1, build 0x00F0, then flush
        t_wbv = 1; t_wba = 15;
        cyc();
        t_wbv = 0;
        for (int r = 4; r < 8; r++) begin
            issue(0, 0, 0, 0, 1, r);
            cyc();
        end
        chk("lit F0 busy1", int'(if1.busy_mask), 'h00F0);
        issue(0, 4, 0, 5, 0, 6);
        #1 chk("lit unused ready0", int'(if0.issue_ready), 1);
        cyc();
        issue(0, 0, 0, 0, 1, 2);
        t_flush = 1; t_wbv = 1; t_wba = 4;
        #1 chk("lit flush ready0", int'(if0.issue_ready), 0);
        cyc();
        chk("lit flush busy0", int'(if0.busy_mask), 0);
        chk("lit flush pend0", int'(if0.pending_count), 0);
        chk("lit flush err0", int'(if0.wb_error), 1);
        chk("lit flush stall0", int'(if0.stall_cycles), 4);
        idle();

        // saturation
        issue(0, 0, 0, 0, 1, 9);
        cyc();
        issue(1, 9, 0, 0, 0, 0);
        repeat (20) cyc();
        chk("lit sat stall1", int'(if1.stall_cycles), 15);
        chk("lit sat stall0", int'(if0.stall_cycles), 24);

        // async reset between edges
        #1 rst_n = 0;
        #1;
        chk("lit arst busy0", int'(if0.busy_mask), 0);
        chk("lit arst stall0", int'(if0.stall_cycles), 0);
        chk("lit arst stall1", int'(if1.stall_cycles), 0);
        chk("lit arst err0", int'(if0.wb_error), 0);
        chk("lit arst pend0", int'(if0.pending_count), 0);
        idle();
        issue(0, 0, 0, 0, 1, 1);
        #1 rst_n = 1;
        cyc();
        chk("lit post-rst busy1", int'(if1.busy_mask), 'h0002);
        idle();
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
